// File: rtl/wb_intgen_multi_if.sv
// Wishbone B3 classic slave bundle for wb_intgen_multi: 8-bit byte address,
// 32-bit data, single-cycle registered ack/err.
interface wb_intgen_multi_if;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_intgen_multi.sv
// Multi-channel Wishbone interrupt generator: NUM_IRQ countdown timers with pending/enable/mode.
// Define WB_INTGEN_MULTI_PRESCALER_EN to add the shared PRESCALE tick divider at index 3.
module wb_intgen_multi #(
    parameter int NUM_IRQ   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_intgen_multi_if.slave    wb,
    output logic [NUM_IRQ-1:0]  irq_o,
    output logic                irq_any_o
);
    localparam logic [5:0] MAX_IDX = 6'(3 + 2 * NUM_IRQ);

    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   enable_q, enable_d;
    logic [NUM_IRQ-1:0]   mode_q, mode_d;
    logic [CNT_WIDTH-1:0] load_q [NUM_IRQ];
    logic [CNT_WIDTH-1:0] load_d [NUM_IRQ];
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_IRQ];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_IRQ];
    logic                 ack_q, ack_d, err_q, err_d;
    logic [31:0]          dat_q, dat_d;

    logic [5:0]  idx;
    logic        access, valid, wr;
    logic        tick;
    logic [31:0] rdata;
    logic        unused_bits;

    assign idx    = wb.wb_adr_i[7:2];
    // ack/err in flight blocks a new access, so held strobes complete every other cycle
    assign access = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign valid  = (idx <= MAX_IDX);
    assign wr     = access & valid & wb.wb_we_i;
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[1:0], wb.wb_dat_i};

`ifdef WB_INTGEN_MULTI_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;

    assign tick = (pre_cnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pre_cnt_d  = tick ? 16'd0 : pre_cnt_q + 16'd1;
        if (wr && idx == 6'd3) begin
            prescale_d = wb.wb_dat_i[15:0];
            pre_cnt_d  = 16'd0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else begin
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Set is applied after the W1C clear so an expiry on the same edge wins.
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        pending_d = pending_q & ~({NUM_IRQ{wr && idx == 6'd0}} & wb.wb_dat_i[NUM_IRQ-1:0]);
        enable_d  = (wr && idx == 6'd1) ? wb.wb_dat_i[NUM_IRQ-1:0] : enable_q;
        mode_d    = (wr && idx == 6'd2) ? wb.wb_dat_i[NUM_IRQ-1:0] : mode_q;
        for (int k = 0; k < NUM_IRQ; k++) begin
            load_d[k] = load_q[k];
            cnt_d[k]  = cnt_q[k];
            if (tick && cnt_q[k] == CNT_WIDTH'(1)) begin
                pending_d[k] = 1'b1;
                cnt_d[k]     = (mode_q[k] && load_q[k] != '0) ? load_q[k] : '0;
            end else if (tick && cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
            end
            if (wr && idx == 6'(4 + 2 * k)) load_d[k] = wb.wb_dat_i[CNT_WIDTH-1:0];
            if (wr && idx == 6'(5 + 2 * k)) cnt_d[k]  = wb.wb_dat_i[CNT_WIDTH-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            6'd0: rdata[NUM_IRQ-1:0] = pending_q;
            6'd1: rdata[NUM_IRQ-1:0] = enable_q;
            6'd2: rdata[NUM_IRQ-1:0] = mode_q;
`ifdef WB_INTGEN_MULTI_PRESCALER_EN
            6'd3: rdata[15:0] = prescale_q;
`endif
            default: ;
        endcase
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (idx == 6'(4 + 2 * k)) rdata[CNT_WIDTH-1:0] = load_q[k];
            if (idx == 6'(5 + 2 * k)) rdata[CNT_WIDTH-1:0] = cnt_q[k];
        end
    end

    assign ack_d = access & valid;
    assign err_d = access & ~valid;
    assign dat_d = (access && valid && !wb.wb_we_i) ? rdata : '0;

    // NOTE: the channel arrays are reset too, because LOAD/COUNT must read 0 after reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            for (int k = 0; k < NUM_IRQ; k++) begin
                load_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            for (int k = 0; k < NUM_IRQ; k++) begin
                load_q[k] <= load_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = pending_q & enable_q;
    assign irq_any_o   = |irq_o;
endmodule

// File: tb/tb_wb_intgen_multi.sv
// Self-checking bench for wb_intgen_multi: directed scenarios plus random bus traffic
// against an expiry-time reference model (each channel tracks the edge at which it fires).
module tb_wb_intgen_multi;
    localparam int NI      = 4;
    localparam int CW      = 16;
    localparam int MAX_IDX = 3 + 2 * NI;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] irq_o;
    logic          irq_any_o;

    wb_intgen_multi_if bus_if ();

    wb_intgen_multi #(.NUM_IRQ(NI), .CNT_WIDTH(CW)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb        (bus_if),
        .irq_o     (irq_o),
        .irq_any_o (irq_any_o)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint now;
    longint last_edge;
    bit     chk_irq = 1'b1;

    // Reference model: pending/enable/mode bits and, per channel, the absolute edge of the next expiry.
    bit [NI-1:0] m_pend, m_en, m_mode;
    longint      m_fire [NI];
    longint      m_last [NI];
    longint      m_load [NI];
    logic [15:0] m_presc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend = '0; m_en = '0; m_mode = '0; m_presc = '0;
        for (int k = 0; k < NI; k++) begin
            m_fire[k] = 0; m_last[k] = -1; m_load[k] = 0;
        end
    endtask

    task automatic m_advance(input longint t);
        for (int k = 0; k < NI; k++) begin
            while (m_fire[k] != 0 && m_fire[k] <= t) begin
                m_pend[k] = 1'b1;
                m_last[k] = m_fire[k];
                if (m_mode[k] && m_load[k] != 0) m_fire[k] = m_fire[k] + m_load[k];
                else m_fire[k] = 0;
            end
        end
    endtask

    task automatic m_write(input int idx, input logic [31:0] d, input longint e);
        longint v;
        int     ch;
        if (idx == 0) begin
            for (int k = 0; k < NI; k++)
                if (d[k] && m_last[k] != e) m_pend[k] = 1'b0;
        end else if (idx == 1) begin
            m_en = d[NI-1:0];
        end else if (idx == 2) begin
            m_mode = d[NI-1:0];
        end else if (idx == 3) begin
`ifdef WB_INTGEN_MULTI_PRESCALER_EN
            m_presc = d[15:0];
`endif
        end else begin
            v  = longint'(d[CW-1:0]);
            ch = (idx - 4) / 2;
            if (idx % 2 == 0) m_load[ch] = v;
            else m_fire[ch] = (v != 0) ? e + v : 0;
        end
    endtask

    function automatic logic [31:0] m_read(input int idx);
        logic [31:0] v;
        int          ch;
        v = '0;
        if (idx == 0) v = 32'(m_pend);
        else if (idx == 1) v = 32'(m_en);
        else if (idx == 2) v = 32'(m_mode);
        else if (idx == 3) v = 32'(m_presc);
        else if (idx <= MAX_IDX) begin
            ch = (idx - 4) / 2;
            if (idx % 2 == 0) v = 32'(m_load[ch]);
            else v = (m_fire[ch] != 0) ? 32'(m_fire[ch] - now) : 32'd0;
        end
        return v;
    endfunction

    task automatic tick_edge();
        @(negedge clk);
        now++;
        m_advance(now);
    endtask

    task automatic check_irq();
        if (chk_irq) begin
            check("irq_o", 32'(irq_o), 32'(m_pend & m_en));
            check("irq_any", 32'(irq_any_o), 32'(|(m_pend & m_en)));
        end
    endtask

    task automatic idle(input int n);
        int r;
        repeat (n) begin
            r = $urandom_range(0, 2);
            bus_if.wb_cyc_i = (r == 1);
            bus_if.wb_stb_i = (r == 2);
            bus_if.wb_we_i  = 1'($urandom_range(0, 1));
            tick_edge();
            check_irq();
            check("idle_ackerr", 32'({bus_if.wb_ack_o, bus_if.wb_err_o}), 32'd0);
            check("idle_dat", bus_if.wb_dat_o, 32'd0);
        end
    endtask

    task automatic bus(input int idx, input bit we, input logic [31:0] wd, output logic [31:0] rd);
        bit          valid;
        logic [31:0] exp_d;
        valid = (idx <= MAX_IDX);
        exp_d = (valid && !we) ? m_read(idx) : 32'd0;
        bus_if.wb_adr_i = {6'(idx), 2'($urandom_range(0, 3))};
        bus_if.wb_dat_i = wd;
        bus_if.wb_sel_i = 4'($urandom);
        bus_if.wb_we_i  = we;
        bus_if.wb_cyc_i = 1'b1;
        bus_if.wb_stb_i = 1'b1;
        tick_edge();
        last_edge = now;
        if (valid && we) m_write(idx, wd, now);
        check_irq();
        check("ack", 32'(bus_if.wb_ack_o), 32'(valid));
        check("err", 32'(bus_if.wb_err_o), 32'(!valid));
        check("rdata", bus_if.wb_dat_o, exp_d);
        rd = bus_if.wb_dat_o;
        bus_if.wb_cyc_i = 1'b0;
        bus_if.wb_stb_i = 1'b0;
        idle(1);
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        logic [31:0] x;
        bus(idx, 1'b1, d, x);
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        bus(idx, 1'b0, 32'd0, d);
    endtask

    task automatic wait_irq(input int k, input int budget, input string tag);
        int n = 0;
        while (!irq_o[k] && n < budget) begin
            idle(1);
            n++;
        end
        check(tag, 32'(irq_o[k]), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.wb_cyc_i = 1'b0;
        bus_if.wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        now = 0;
        check("rst_ackerr", 32'({bus_if.wb_ack_o, bus_if.wb_err_o}), 32'd0);
        check("rst_dat", bus_if.wb_dat_o, 32'd0);
        check("rst_irq", 32'({irq_any_o, irq_o}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] d;
        longint      e, t_prev;
        int          idx;
        bit          we;

        bus_if.wb_adr_i = '0; bus_if.wb_dat_i = '0; bus_if.wb_sel_i = '0;
        bus_if.wb_we_i = 1'b0; bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0;
        m_reset();
        do_reset();

        // Every mapped index reads 0 after reset; the first unmapped one errors.
        for (int i = 0; i <= MAX_IDX; i++) begin
            rd(i, d);
            check("rst_read", d, 32'd0);
        end
        rd(MAX_IDX + 1, d);
        rd(63, d);

        // A held strobe is acknowledged on alternate cycles.
        bus_if.wb_adr_i = 8'd4; bus_if.wb_we_i = 1'b0;
        bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_edge();
            check_irq();
            check("b2b_ack", 32'(bus_if.wb_ack_o), 32'(i % 2 == 0));
        end
        bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0;
        idle(1);

        // One-shot latency on channel 0.
        wr(1, 32'h1);
        wr(5, 32'd5);
        e = last_edge;
        wait_irq(0, 20, "lat0_seen");
        check("lat0", 32'(now - e), 32'd5);
        check("lat0_any", 32'(irq_any_o), 32'd1);
        rd(0, d); check("lat0_status", d, 32'h1);
        rd(5, d); check("lat0_count", d, 32'd0);
        wr(0, 32'h1);
        check("lat0_clr", 32'(irq_o), 32'd0);

        // Periodic channel 1, period 3, acknowledged each time.
        wr(2, 32'h2); wr(6, 32'd3); wr(1, 32'h2); wr(7, 32'd3);
        t_prev = last_edge;
        for (int p = 0; p < 4; p++) begin
            wait_irq(1, 10, "per_seen");
            check("per_gap", 32'(now - t_prev), 32'd3);
            t_prev = now;
            wr(0, 32'h2);
        end
        // This stop lands on the next expiry edge: pending still sets, count ends at 0.
        wr(7, 32'd0);
        rd(0, d); check("stop_race_pend", d, 32'h2);
        rd(7, d); check("stop_count", d, 32'd0);
        wr(0, 32'h2);
        idle(10);
        rd(0, d); check("per_stopped", d, 32'd0);

        // Masking: two channels pending, only one enabled.
        wr(1, 32'h1); wr(5, 32'd4); wr(9, 32'd4);
        idle(6);
        rd(0, d); check("mask_status", d, 32'h5);
        check("mask_irq", 32'(irq_o), 32'h1);
        wr(1, 32'h5);
        check("mask_irq_both", 32'(irq_o), 32'h5);
        wr(1, 32'h0);
        check("mask_retained", 32'(irq_o), 32'h0);
        wr(1, 32'h4);
        check("mask_reenabled", 32'(irq_o), 32'h4);

        // W1C landing on the expiry edge of channel 0.
        wr(0, 32'hFFFF_FFFF); wr(1, 32'h1); wr(5, 32'd3);
        idle(1);
        wr(0, 32'h1);
        rd(0, d); check("w1c_race", d, 32'h1);

        // Reset during a countdown with a strobe in flight.
        wr(9, 32'd100);
        idle(20);
        bus_if.wb_adr_i = 8'd36; bus_if.wb_we_i = 1'b0;
        bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_inflight", 32'({bus_if.wb_ack_o, bus_if.wb_err_o}), 32'd0);
        rst = 1'b0;
        bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0;
        m_reset();
        now = 0;
        check("rst_mid_irq", 32'(irq_o), 32'd0);
        rd(9, d); check("rst_mid_count", d, 32'd0);
        idle(110);
        rd(0, d); check("rst_mid_status", d, 32'd0);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            idx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(MAX_IDX + 1, 63))
                                               : int'($urandom_range(0, MAX_IDX));
            we  = 1'($urandom_range(0, 1));
            if (idx >= 4 && idx <= MAX_IDX)
                d = (idx % 2 == 1) ? 32'($urandom_range(0, 12)) : 32'($urandom_range(0, 6));
            else
                d = $urandom;
`ifdef WB_INTGEN_MULTI_PRESCALER_EN
            if (idx == 3) d = 32'd0;
`endif
            bus(idx, we, d, d);
            idle($urandom_range(0, 3));
        end

`ifdef WB_INTGEN_MULTI_PRESCALER_EN
        // Prescaled countdown: PRESCALE=3 gives a tick every 4 cycles, so 2 ticks is about 8 cycles.
        do_reset();
        chk_irq = 1'b0;
        wr(1, 32'h1);
        wr(3, 32'd3);
        e = last_edge;
        wr(5, 32'd2);
        wait_irq(0, 30, "pre_seen");
        check("pre_lat", 32'(now - e >= 7 && now - e <= 9), 32'd1);
        chk_irq = 1'b1;
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
